// File: rtl/cpu_bus_ctrl.sv
// M-cycle sequencer and memory bus front end: runs one bus request per M-cycle
// as four T-states (T3 stretchable by mem_wait) and captures fetch/read data.
module cpu_bus_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        bus_op,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_wait,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] ir,
  output logic              ir_cb,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              m_tick,
  output logic [1:0]        t_state
);

  typedef enum logic [2:0] {
    OP_IDLE  = 3'd0,
    OP_IF    = 3'd1,
    OP_WRITE = 3'd2,
    OP_READ  = 3'd3,
    OP_IF_CB = 3'd4
  } bus_opcode_t;

  typedef enum logic [1:0] {T1 = 2'd0, T2 = 2'd1, T3 = 2'd2, T4 = 2'd3} tstate_t;

  tstate_t           t_q, t_d;
  bus_opcode_t       op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              ir_cb_q, ir_cb_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              stall;
  logic              is_rd_op;

  // mem_wait only matters while a real bus access is sitting in T3
  assign stall    = (t_q == T3) && mem_wait && (op_q != OP_IDLE);
  assign is_rd_op = (op_q == OP_IF) || (op_q == OP_IF_CB) || (op_q == OP_READ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q        <= T4;
      op_q       <= OP_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      ir_q       <= '0;
      ir_cb_q    <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      t_q        <= t_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ir_q       <= ir_d;
      ir_cb_q    <= ir_cb_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_comb begin
    t_d        = t_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ir_d       = ir_q;
    ir_cb_d    = ir_cb_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;

    unique case (t_q)
      T1: t_d = T2;
      T2: t_d = T3;
      T3: t_d = stall ? T3 : T4;
      T4: t_d = T1;
      default: t_d = T4;
    endcase

    // Request is latched only on the T4->T1 edge; undefined opcodes become IDLE
    if (t_q == T4) begin
      op_d       = (bus_op <= 3'd4) ? bus_opcode_t'(bus_op) : OP_IDLE;
      addr_d     = bus_addr;
      wdata_d    = bus_wdata;
      rd_valid_d = 1'b0;
    end

    if ((t_q == T3) && !stall) begin
      unique case (op_q)
        OP_IF: begin
          ir_d    = mem_rdata;
          ir_cb_d = 1'b0;
        end
        OP_IF_CB: begin
          ir_d    = mem_rdata;
          ir_cb_d = 1'b1;
        end
        OP_READ: begin
          rd_data_d  = mem_rdata;
          rd_valid_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = (op_q == OP_WRITE) ? wdata_q : '0;
  assign mem_rd    = is_rd_op && ((t_q == T2) || (t_q == T3));
  assign mem_wr    = (op_q == OP_WRITE) && (t_q == T3);
  assign ir        = ir_q;
  assign ir_cb     = ir_cb_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign m_tick    = (t_q == T4);
  assign t_state   = t_q;

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Scoreboarded bench for cpu_bus_ctrl: each issued request pushes its expected
// M-cycle outcome; a negedge monitor summarises each M-cycle and compares at T4.
module tb_cpu_bus_ctrl;
  localparam int AW = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    bus_op;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_wait;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rd, mem_wr;
  logic [DW-1:0] ir;
  logic          ir_cb;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          m_tick;
  logic [1:0]    t_state;

  cpu_bus_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .bus_op(bus_op), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .mem_rdata(mem_rdata), .mem_wait(mem_wait),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .ir(ir), .ir_cb(ir_cb), .rd_data(rd_data), .rd_valid(rd_valid),
    .m_tick(m_tick), .t_state(t_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            len;
    int            rdc;
    int            wrc;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [DW-1:0] ir_pre;
    logic [DW-1:0] ir;
    logic          ircb;
    logic [DW-1:0] rd;
    logic          rdv;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic mon_en = 1'b0;

  // Architectural state of the reference model
  logic [DW-1:0] m_ir = '0;
  logic [DW-1:0] m_rd = '0;
  logic          m_ircb = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Must be entered while the DUT is in T4; returns at the T4 of this request's M-cycle.
  task automatic issue(input logic [2:0] op, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic [DW-1:0] rv, input int w);
    exp_t e;
    int   kind, stall, left, b;
    if (m_tick !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL issue_align: m_tick=%b, expected 1", m_tick);
      return;
    end
    bus_op = op; bus_addr = a; bus_wdata = wd;
    mem_wait = 1'($urandom_range(0, 1)); mem_rdata = DW'($urandom);
    kind  = (op > 3'd4) ? 0 : int'(op);
    stall = (kind != 0) ? w : 0;
    e.ir_pre = m_ir;
    e.len  = 4 + stall;
    e.rdc  = (kind == 1 || kind == 3 || kind == 4) ? 2 + stall : 0;
    e.wrc  = (kind == 2) ? 1 + stall : 0;
    e.addr = a;
    e.wd   = (kind == 2) ? wd : '0;
    if (kind == 1) begin m_ir = rv; m_ircb = 1'b0; end
    else if (kind == 4) begin m_ir = rv; m_ircb = 1'b1; end
    else if (kind == 3) m_rd = rv;
    e.ir = m_ir; e.ircb = m_ircb; e.rd = m_rd; e.rdv = (kind == 3);
    q.push_back(e);
    left = w; b = 0;
    @(negedge clk);
    while (m_tick !== 1'b1 && b < 40) begin
      if (t_state == 2'd2) begin
        if (left > 0) begin mem_wait = 1'b1; mem_rdata = DW'($urandom); left--; end
        else begin mem_wait = 1'b0; mem_rdata = rv; end
      end else begin
        mem_wait = 1'($urandom_range(0, 1)); mem_rdata = DW'($urandom);
      end
      bus_op = 3'($urandom); bus_addr = AW'($urandom); bus_wdata = DW'($urandom);
      @(negedge clk); b++;
    end
    if (m_tick !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL mcycle_timeout: no m_tick within %0d clocks", b);
    end
  endtask

  // Monitor: summarise one M-cycle from T1 to T4, then score it
  logic          active = 1'b0;
  int            o_len, o_rdc, o_wrc;
  logic [AW-1:0] o_a0;
  logic          o_abad, o_rvbad;
  logic [DW-1:0] o_wd, o_irp;
  exp_t          me;

  always @(negedge clk) begin
    if (!rst_n || !mon_en) begin
      active = 1'b0;
    end else begin
      if (t_state == 2'd0) begin
        active = 1'b1; o_len = 0; o_rdc = 0; o_wrc = 0;
        o_a0 = mem_addr; o_abad = 1'b0; o_rvbad = 1'b0;
      end
      if (active) begin
        o_len++;
        o_rdc += int'(mem_rd);
        o_wrc += int'(mem_wr);
        if (mem_addr !== o_a0) o_abad = 1'b1;
        if (t_state != 2'd3 && rd_valid !== 1'b0) o_rvbad = 1'b1;
        if (t_state == 2'd1) o_irp = ir;
        if (t_state == 2'd2) o_wd = mem_wdata;
      end
      if (active && m_tick) begin
        if (q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL scoreboard_empty: M-cycle completed with no expected entry");
        end else begin
          me = q.pop_front();
          chk("mcycle_len",   o_len, me.len);
          chk("rd_clocks",    o_rdc, me.rdc);
          chk("wr_clocks",    o_wrc, me.wrc);
          chk("mem_addr",     32'(o_a0), 32'(me.addr));
          chk("addr_stable",  32'(o_abad), 0);
          chk("mem_wdata",    32'(o_wd), 32'(me.wd));
          chk("ir_before_t4", 32'(o_irp), 32'(me.ir_pre));
          chk("ir",           32'(ir), 32'(me.ir));
          chk("ir_cb",        32'(ir_cb), 32'(me.ircb));
          chk("rd_data",      32'(rd_data), 32'(me.rd));
          chk("rd_valid_t4",  32'(rd_valid), 32'(me.rdv));
          chk("rd_valid_off", 32'(o_rvbad), 0);
          chk("t4_state",     32'(t_state), 3);
        end
        active = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b;
    rst_n = 1'b0; bus_op = '0; bus_addr = '0; bus_wdata = '0;
    mem_rdata = '0; mem_wait = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_t_state", 32'(t_state), 3);
    chk("rst_m_tick",  32'(m_tick), 1);
    chk("rst_mem_rd",  32'(mem_rd), 0);
    chk("rst_mem_wr",  32'(mem_wr), 0);
    chk("rst_ir",      32'(ir), 0);
    chk("rst_ir_cb",   32'(ir_cb), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_rd_valid",32'(rd_valid), 0);
    chk("rst_addr",    32'(mem_addr), 0);
    chk("rst_wdata",   32'(mem_wdata), 0);
    #1 rst_n = 1'b1; mon_en = 1'b1;
    chk("tick_clk0", 32'(m_tick), 1);

    issue(3'd1, 16'h0100, 8'h11, 8'h3E, 0);   // IF
    issue(3'd4, 16'h0201, 8'h22, 8'h37, 0);   // IF_CB
    issue(3'd1, 16'h0202, 8'h33, 8'h00, 0);   // IF
    issue(3'd2, 16'hFF80, 8'hA5, 8'h99, 0);   // WRITE
    issue(3'd3, 16'hC000, 8'h44, 8'h5A, 3);   // READ, 3 wait clocks
    issue(3'd0, 16'h1234, 8'h55, 8'h66, 2);   // IDLE, wait ignored
    issue(3'd6, 16'h4321, 8'h77, 8'h88, 1);   // undefined op -> IDLE
    issue(3'd2, 16'h8000, 8'h5C, 8'h01, 2);   // stretched WRITE
    for (int i = 0; i < 250; i++)
      issue(3'($urandom_range(0, 7)), AW'($urandom), DW'($urandom), DW'($urandom),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);

    // Reset mid-write during T3
    #1 mon_en = 1'b0;
    bus_op = 3'd2; bus_addr = 16'hBEEF; bus_wdata = 8'hC3; mem_wait = 1'b0;
    b = 0;
    @(negedge clk);
    while (t_state != 2'd2 && b < 10) begin @(negedge clk); b++; end
    chk("mid_wr_high",  32'(mem_wr), 1);
    chk("mid_wr_data",  32'(mem_wdata), 32'h00C3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mem_wr",  32'(mem_wr), 0);
    chk("arst_mem_rd",  32'(mem_rd), 0);
    chk("arst_ir",      32'(ir), 0);
    chk("arst_t_state", 32'(t_state), 3);
    chk("arst_rd_valid",32'(rd_valid), 0);
    q.delete();
    m_ir = '0; m_ircb = 1'b0; m_rd = '0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1; mon_en = 1'b1;
    issue(3'd4, 16'h0010, 8'h00, 8'hCB, 0);   // captured on first edge after release
    for (int i = 0; i < 40; i++)
      issue(3'($urandom_range(0, 7)), AW'($urandom), DW'($urandom), DW'($urandom),
            ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
    #1;
    chk("queue_drained", 32'(q.size()), 0);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cpu_bus_ctrl.md
Name: cpu_bus_ctrl

Overview:
- M-cycle sequencer and memory bus interface for the CPU core. Sits between the control unit and the external memory bus.
- Each M-cycle it accepts one bus_opcode_t request (IDLE, IF, WRITE, READ, IF_CB) with an address and write data, and runs it as four T-states.
- Fetched opcodes go into the instruction register; READ data is returned to the datapath.
- Provides the M-cycle tick that paces the control unit.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 8, memory data width.

Ports:
- clk  input  1  core clock, one T-state per cycle
- rst_n  input  1  asynchronous active-low reset
- bus_op  input  3  bus_opcode_t request for the next M-cycle
- bus_addr  input  ADDR_W  address for the next M-cycle (resolved upstream from register_nn_t)
- bus_wdata  input  DATA_W  write data for the next M-cycle
- mem_rdata  input  DATA_W  read data from memory
- mem_wait  input  1  memory not ready; stretches T3
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rd  output  1  read strobe
- mem_wr  output  1  write strobe
- ir  output  DATA_W  instruction register
- ir_cb  output  1  ir holds a CB-prefixed opcode
- rd_data  output  DATA_W  last READ result
- rd_valid  output  1  rd_data updated this M-cycle
- m_tick  output  1  last T-state of the current M-cycle
- t_state  output  2  current T-state, 0=T1 .. 3=T4

Behaviour:
- Reset (async, rst_n=0) forces:
  - t_state=T4, op_q=IDLE, addr_q=0x0000, wdata_q=0x00.
  - ir=0x00 (NOP), ir_cb=0, rd_data=0x00, rd_valid=0.
  - mem_rd=0, mem_wr=0 immediately, including mid-cycle.
- T-state counter: 2-bit, advances T1→T2→T3→T4→T1 on each clk.
  - Exception: stays in T3 while mem_wait=1 and op_q≠IDLE. mem_wait is ignored in all other T-states.
- m_tick = (t_state==T4), combinational from the registered state. It is high in the first clock after reset release.
- Request capture: on the clk edge leaving T4, latch bus_op→op_q, bus_addr→addr_q, bus_wdata→wdata_q.
  - The control unit holds the request valid during T4 of the preceding M-cycle.
  - bus_op values 5–7 latch as IDLE.
- Bus outputs are combinational from registered state:
  - mem_addr = addr_q, held for the whole M-cycle.
  - mem_rd = (op_q ∈ {IF, IF_CB, READ}) && t_state ∈ {T2, T3}.
  - mem_wr = (op_q==WRITE) && t_state==T3. Stays high during a stretched T3.
  - mem_wdata = wdata_q when op_q==WRITE, else 0x00.
- Read capture on the clk edge leaving T3 (not stalled):
  - IF: ir←mem_rdata, ir_cb←0.
  - IF_CB: ir←mem_rdata, ir_cb←1.
  - READ: rd_data←mem_rdata. ir and ir_cb unchanged.
- rd_valid: registered. Set on the edge leaving T3 of a READ, cleared on the edge leaving T4. It is therefore high exactly during T4 of a READ M-cycle.
- WRITE and IDLE cycles leave ir, ir_cb and rd_data unchanged.
- Latency: M-cycle = 4 clocks + stall clocks. Fetched data is visible on ir during T4 of the same M-cycle.
- A new request changes no output until the T4→T1 edge.

Test Plan:
1. Release reset with bus_op=IF, bus_addr=0x0100; memory returns 0x3E.
   → m_tick in clock 0. mem_addr=0x0100 and mem_rd=1 in clocks 2–3. ir=0x3E, ir_cb=0 from clock 4. m_tick repeats every 4 clocks.
2. IF_CB at 0x0201 returning 0x37, then IF returning 0x00.
   → ir=0x37, ir_cb=1 after the first M-cycle. ir=0x00, ir_cb=0 after the second.
3. WRITE to 0xFF80 with data 0xA5.
   → mem_wr=1 for exactly one clock (T3), mem_wdata=0xA5, mem_rd=0 throughout. ir, rd_data and rd_valid unchanged.
4. READ at 0xC000 with mem_wait=1 for 3 clocks at T3, memory presenting 0x5A on release.
   → M-cycle spans 7 clocks, m_tick delayed 3 clocks, mem_rd high for 5 clocks. rd_data=0x5A and rd_valid=1 only in T4.
5. Back-to-back IDLE and bus_op=3'b110.
   → no mem_rd or mem_wr. ir unchanged. m_tick every 4 clocks.
6. Assert rst_n=0 during T3 of a WRITE.
   → mem_wr drops asynchronously, ir=0x00, t_state=T4. After release, the next request is captured on the first edge.
